// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared constants, FSM state type and tag width helper for the adder stream arbiter
// Contents:
//   W_DEF       default operand/result width of the shared adder core
//   LAT_DEF     issue-to-result latency of the adder core (cycles)
//   arb_state_t sequencer states IDLE / RUN / DRAIN
//   tag_width() tag width for N requesters, never below 1 bit
package adder_arb_pkg;

    localparam int W_DEF   = 11;
    localparam int LAT_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    function automatic int tag_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-of-N picker with last-winner pointer
// Ports:
//   ap_clk, ap_rst_n  clock, asynchronous active-low reset
//   req       [N]     request vector
//   advance           a grant is taken this cycle; pointer moves to the winner
//   grant     [N]     one-hot winner (combinational, all zero when no request)
//   grant_idx [TAG_W] index of the winner
//   any               at least one request set
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int N     = 4,
    localparam int TAG_W = tag_width(N)
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [TAG_W-1:0] grant_idx,
    output logic             any
);

    logic [TAG_W-1:0] ptr;
    logic [TAG_W-1:0] cand;
    logic             found;

    // Pointer holds the last winner; reset to N-1 so requester 0 is scanned first.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr <= TAG_W'(N - 1);
        end else if (advance) begin
            ptr <= grant_idx;
        end
    end

    // Scan ptr+1, ptr+2, ... ptr+N (mod N); first set request wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = TAG_W'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/adder_stream_arbiter.sv
// rtl/adder_stream_arbiter.sv - shares one 2-stage adder core among N requester streams with tagged results
// Ports:
//   ap_clk, ap_rst_n          clock, asynchronous active-low reset
//   en                        arbitration enable (0 = drain then idle)
//   req_valid/req_a/req_b     N requester operand pairs, requester i at [i*W +: W]
//   req_ready [N]             one-hot pop pulse for the consumed pair
//   add_ce/add_start/add_rst  adder clock enable, start, active-high reset
//   add_a/add_b, add_z        adder operands out, adder sum in
//   res_valid/res_ready       result stream handshake
//   res_data/res_tag          sum and originating requester index
//   busy, idle                operation in flight, sequencer in IDLE
module adder_stream_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int W     = W_DEF,
    parameter  int N     = 4,
    parameter  int LAT   = LAT_DEF,
    localparam int TAG_W = tag_width(N)
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             en,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_a,
    input  logic [N*W-1:0]   req_b,
    output logic [N-1:0]     req_ready,
    output logic             add_ce,
    output logic             add_start,
    output logic             add_rst,
    output logic [W-1:0]     add_a,
    output logic [W-1:0]     add_b,
    input  logic [W-1:0]     add_z,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy,
    output logic             idle
);

    arb_state_t       state, state_nx;
    logic [1:0]       rst_sync;
    logic             stall;
    logic             grant_en;
    logic [N-1:0]     arb_grant;
    logic [TAG_W-1:0] win_idx;
    logic             arb_any;
    logic [W-1:0]     a_arr [N];
    logic [W-1:0]     b_arr [N];
    logic [LAT-1:0]   pipe_v;
    logic [TAG_W-1:0] pipe_tag [LAT];

    // Adder reset: asserts with ap_rst_n, releases on the second clock edge after it.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign add_rst = ~rst_sync[1];

    // A held result freezes the adder and the tag pipe together.
    assign stall  = res_valid & ~res_ready;
    assign add_ce = ~stall & ~add_rst;

    rr_arbiter #(.N(N)) u_rr (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req       (req_valid),
        .advance   (grant_en),
        .grant     (arb_grant),
        .grant_idx (win_idx),
        .any       (arb_any)
    );

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*W +: W];
        assign b_arr[i] = req_b[i*W +: W];
    end

    assign req_ready = grant_en ? arb_grant : '0;
    assign add_start = grant_en;
    assign add_a     = a_arr[win_idx];
    assign add_b     = b_arr[win_idx];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        grant_en = 1'b0;
        idle     = 1'b0;
        case (state)
            ST_IDLE: begin
                idle = 1'b1;
                if (en && !add_rst) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                grant_en = add_ce & arb_any;
                if (!en) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (en) begin
                    state_nx = ST_RUN;
                end else if (!busy && !res_valid) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Shadow of the adder pipeline: advances in lockstep with add_ce so each
    // tag lines up with its sum at the adder output.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            pipe_v <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_tag[i] <= '0;
            end
        end else if (add_ce) begin
            pipe_v[0]   <= grant_en;
            pipe_tag[0] <= win_idx;
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    assign res_valid = pipe_v[LAT-1];
    assign res_tag   = pipe_tag[LAT-1];
    assign res_data  = add_z;
    assign busy      = |pipe_v;

endmodule

// File: tb/tb_adder_stream_arbiter.sv
// tb/tb_adder_stream_arbiter.sv - directed self-checking bench for adder_stream_arbiter with a 2-stage adder model
module tb_adder_stream_arbiter;

    localparam int W     = 11;
    localparam int N     = 4;
    localparam int TAG_W = 2;

    logic             ap_clk = 1'b0;
    logic             ap_rst_n;
    logic             en;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic             add_ce;
    logic             add_start;
    logic             add_rst;
    logic [W-1:0]     add_a;
    logic [W-1:0]     add_b;
    logic [W-1:0]     add_z;
    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_data;
    logic [TAG_W-1:0] res_tag;
    logic             busy;
    logic             idle;

    logic [W-1:0]     s1;

    int n_checks = 0;
    int n_fail   = 0;
    int stale    = 0;

    int exp_g   [5] = '{8, 1, 2, 4, 8};
    int exp_t   [5] = '{3, 0, 1, 2, 3};
    int rr_sum  [4] = '{'h111, 'h322, 'h533, 'h354};

    always #5 ap_clk = ~ap_clk;

    adder_stream_arbiter dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .add_ce    (add_ce),
        .add_start (add_start),
        .add_rst   (add_rst),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_z     (add_z),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_tag   (res_tag),
        .busy      (busy),
        .idle      (idle)
    );

    // Two-stage adder core model: sum registered twice, frozen when ce=0.
    always_ff @(posedge ap_clk) begin
        if (add_rst) begin
            s1    <= '0;
            add_z <= '0;
        end else if (add_ce) begin
            s1    <= add_a + add_b;
            add_z <= s1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    initial begin
        ap_rst_n  = 1'b0;
        en        = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge ap_clk);
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'h0);
        check_eq("rst_add_ce",    32'(add_ce),    32'h0);
        check_eq("rst_add_start", 32'(add_start), 32'h0);
        check_eq("rst_add_rst",   32'(add_rst),   32'h1);
        check_eq("rst_res_valid", 32'(res_valid), 32'h0);
        check_eq("rst_res_tag",   32'(res_tag),   32'h0);
        check_eq("rst_busy",      32'(busy),      32'h0);
        check_eq("rst_idle",      32'(idle),      32'h1);

        // Reset release: add_rst drops on the second edge, RUN one edge later
        ap_rst_n = 1'b1;
        @(negedge ap_clk); #1;
        check_eq("rel_add_rst_e1", 32'(add_rst), 32'h1);
        @(negedge ap_clk); #1;
        check_eq("rel_add_rst_e2", 32'(add_rst), 32'h0);
        check_eq("rel_idle_e2",    32'(idle),    32'h1);
        @(negedge ap_clk); #1;
        check_eq("rel_idle_e3",    32'(idle),      32'h0);
        check_eq("rel_add_ce",     32'(add_ce),    32'h1);
        check_eq("rel_res_valid",  32'(res_valid), 32'h0);

        // Single op from requester 2
        @(negedge ap_clk);
        set_op(2, 11'h005, 11'h00A);
        req_valid = 4'b0100;
        #1;
        check_eq("one_req_ready", 32'(req_ready), 32'h4);
        check_eq("one_add_start", 32'(add_start), 32'h1);
        check_eq("one_add_a",     32'(add_a),     32'h005);
        check_eq("one_add_b",     32'(add_b),     32'h00A);
        @(negedge ap_clk);
        req_valid = '0;
        #1;
        check_eq("one_res_valid_t1", 32'(res_valid), 32'h0);
        check_eq("one_busy_t1",      32'(busy),      32'h1);
        @(negedge ap_clk); #1;
        check_eq("one_res_valid_t2", 32'(res_valid), 32'h1);
        check_eq("one_res_data",     32'(res_data),  32'h00F);
        check_eq("one_res_tag",      32'(res_tag),   32'h2);
        @(negedge ap_clk); #1;
        check_eq("one_res_valid_t3", 32'(res_valid), 32'h0);

        // Round robin, all four requesting; last winner was 2
        set_op(0, 11'h011, 11'h100);
        set_op(1, 11'h122, 11'h200);
        set_op(2, 11'h233, 11'h300);
        set_op(3, 11'h344, 11'h010);
        for (int c = 0; c < 7; c++) begin
            @(negedge ap_clk);
            req_valid = (c < 5) ? 4'hF : 4'h0;
            #1;
            if (c < 5) begin
                check_eq($sformatf("rr_grant%0d", c), 32'(req_ready), 32'(exp_g[c]));
            end
            if (c >= 2) begin
                check_eq($sformatf("rr_valid%0d", c), 32'(res_valid), 32'h1);
                check_eq($sformatf("rr_tag%0d", c),   32'(res_tag),   32'(exp_t[c-2]));
                check_eq($sformatf("rr_data%0d", c),  32'(res_data),  32'(rr_sum[exp_t[c-2]]));
            end
        end

        // Backpressure, with the wrap case 0x7FF + 0x002 in flight
        set_op(0, 11'h050, 11'h005);
        set_op(1, 11'h7FF, 11'h002);
        set_op(2, 11'h400, 11'h3FF);
        @(negedge ap_clk);
        req_valid = 4'b0011;
        #1;
        check_eq("bp_grant0", 32'(req_ready), 32'h1);
        @(negedge ap_clk);
        req_valid = 4'b0010;
        #1;
        check_eq("bp_grant1", 32'(req_ready), 32'h2);
        @(negedge ap_clk);
        req_valid = 4'b0100;
        res_ready = 1'b0;
        #1;
        check_eq("bp_valid",  32'(res_valid), 32'h1);
        check_eq("bp_tag",    32'(res_tag),   32'h0);
        check_eq("bp_data",   32'(res_data),  32'h055);
        check_eq("bp_ce",     32'(add_ce),    32'h0);
        check_eq("bp_noissue", 32'(req_ready), 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge ap_clk); #1;
            check_eq($sformatf("bp_hold_ce%0d", c),    32'(add_ce),    32'h0);
            check_eq($sformatf("bp_hold_ready%0d", c), 32'(req_ready), 32'h0);
            check_eq($sformatf("bp_hold_valid%0d", c), 32'(res_valid), 32'h1);
            check_eq($sformatf("bp_hold_tag%0d", c),   32'(res_tag),   32'h0);
            check_eq($sformatf("bp_hold_data%0d", c),  32'(res_data),  32'h055);
        end
        @(negedge ap_clk);
        res_ready = 1'b1;
        #1;
        check_eq("bp_resume_grant", 32'(req_ready), 32'h4);
        check_eq("bp_resume_tag",   32'(res_tag),   32'h0);
        check_eq("bp_resume_ce",    32'(add_ce),    32'h1);
        @(negedge ap_clk);
        req_valid = '0;
        #1;
        check_eq("bp_r1_valid", 32'(res_valid), 32'h1);
        check_eq("bp_r1_tag",   32'(res_tag),   32'h1);
        check_eq("wrap_data",   32'(res_data),  32'h001);
        @(negedge ap_clk); #1;
        check_eq("bp_r2_valid", 32'(res_valid), 32'h1);
        check_eq("bp_r2_tag",   32'(res_tag),   32'h2);
        check_eq("bp_r2_data",  32'(res_data),  32'h7FF);
        @(negedge ap_clk); #1;
        check_eq("bp_empty", 32'(res_valid), 32'h0);

        // Drain: en falls while an issue is still granted, then idle
        set_op(3, 11'h123, 11'h321);
        @(negedge ap_clk);
        req_valid = 4'b1000;
        #1;
        check_eq("dr_grant3", 32'(req_ready), 32'h8);
        @(negedge ap_clk);
        req_valid = 4'b0001;
        en        = 1'b0;
        #1;
        check_eq("dr_grant0_en_fall", 32'(req_ready), 32'h1);
        @(negedge ap_clk);
        req_valid = 4'b0010;
        #1;
        check_eq("dr_no_grant", 32'(req_ready), 32'h0);
        check_eq("dr_r0_valid", 32'(res_valid), 32'h1);
        check_eq("dr_r0_tag",   32'(res_tag),   32'h3);
        check_eq("dr_r0_data",  32'(res_data),  32'h444);
        @(negedge ap_clk); #1;
        check_eq("dr_r1_tag",  32'(res_tag),  32'h0);
        check_eq("dr_r1_data", 32'(res_data), 32'h055);
        check_eq("dr_r1_idle", 32'(idle),     32'h0);
        @(negedge ap_clk); #1;
        check_eq("dr_empty_valid", 32'(res_valid), 32'h0);
        check_eq("dr_empty_busy",  32'(busy),      32'h0);
        check_eq("dr_empty_idle",  32'(idle),      32'h0);
        @(negedge ap_clk); #1;
        check_eq("dr_idle",     32'(idle),      32'h1);
        check_eq("dr_idle_rdy", 32'(req_ready), 32'h0);

        // Reset pulsed with two ops in flight
        @(negedge ap_clk);
        en        = 1'b1;
        req_valid = '0;
        #1;
        check_eq("mr_idle_pre", 32'(idle), 32'h1);
        @(negedge ap_clk);
        req_valid = 4'b0010;
        #1;
        check_eq("mr_grant1", 32'(req_ready), 32'h2);
        @(negedge ap_clk);
        req_valid = 4'b0100;
        #1;
        check_eq("mr_grant2", 32'(req_ready), 32'h4);
        @(negedge ap_clk);
        req_valid = '0;
        #1;
        check_eq("mr_valid_pre", 32'(res_valid), 32'h1);
        check_eq("mr_tag_pre",   32'(res_tag),   32'h1);
        #1;
        ap_rst_n = 1'b0;
        #1;
        check_eq("mr_valid_async", 32'(res_valid), 32'h0);
        check_eq("mr_busy_async",  32'(busy),      32'h0);
        check_eq("mr_add_rst",     32'(add_rst),   32'h1);
        check_eq("mr_idle",        32'(idle),      32'h1);
        check_eq("mr_tag",         32'(res_tag),   32'h0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge ap_clk); #1;
            if (res_valid) stale++;
        end
        check_eq("mr_no_stale",  32'(stale), 32'h0);
        check_eq("mr_rerun_idle", 32'(idle), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_stream_arbiter.md
Name: adder_stream_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one instance of the 2-stage SIMD adder stream core among N requester streams.
- Picks at most one operand pair per cycle and drives the adder's operand, start and clock-enable inputs.
- Tracks a requester tag alongside each operation through a shadow pipeline and returns each sum with its tag on one output stream.
- Applies output backpressure by freezing the adder through its clock enable.

Parameters:
- W, 11, operand/result width (matches adder core).
- N, 4, number of requesters (2..16).
- LAT, 2, adder latency in cycles from issue to result; fixed by the adder core.
- TAG_W, $clog2(N), tag width (localparam, min 1).

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- en  in  1  arbitration enable; 0 requests drain-and-idle.
- req_valid  in  N  requester i has an operand pair.
- req_a  in  N*W  operand A, requester i at bits [i*W +: W].
- req_b  in  N*W  operand B, same packing.
- req_ready  out  N  one-hot pop pulse: pair i consumed this cycle.
- add_ce  out  1  adder ap_ce.
- add_start  out  1  adder ap_start (1 on issue cycles).
- add_rst  out  1  active-high reset to adder core.
- add_a  out  W  adder artl.
- add_b  out  W  adder brtl.
- add_z  in  W  adder z.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_data  out  W  sum, equal to add_z.
- res_tag  out  TAG_W  requester index of res_data.
- busy  out  1  any operation in flight.
- idle  out  1  FSM in IDLE.

Behaviour:
- Reset values (async on ap_rst_n=0): req_ready=0, add_ce=0, add_start=0, add_rst=1, res_valid=0, res_tag=0, busy=0, idle=1. RR pointer = N-1, so requester 0 has first priority.
- add_rst: 2-flop synchroniser. Asserts asynchronously with reset; deasserts on the 2nd rising ap_clk after ap_rst_n rises. No grants while add_rst=1.
- Stall: stall = res_valid & ~res_ready.
  - add_ce = ~stall & ~add_rst.
  - While stalled: no grant; tag pipe and adder hold; res_data/res_tag/res_valid stable.
- Grant (combinational in the issue cycle):
  - Allowed only in RUN, with add_ce=1, and with at least one req_valid set.
  - Winner = first valid index scanning pointer+1, pointer+2, … modulo N.
  - req_ready[winner]=1 and add_a/add_b = winner's operands in the same cycle; add_start=1.
  - Pointer <= winner on the clock edge. Pointer is unchanged on cycles with no grant.
- Shadow pipe: LAT stages of {valid, tag}, advanced only when add_ce=1. Stage 0 captures {grant, winner}. res_valid/res_tag = last stage.
- Latency: issue in cycle t (no stall) gives res_valid=1 with res_data = (A+B) mod 2^W in cycle t+LAT. Stalls extend this one cycle per stalled cycle.
- Arithmetic: W-bit wrap, no carry out; 0x7FF+0x001 = 0x000.
- Throughput: one issue per cycle when unstalled. Result ordering equals issue order.
- FSM:
  - IDLE: idle=1. Goes to RUN when en=1 and add_rst=0.
  - RUN: grants allowed. Goes to DRAIN when en=0.
  - DRAIN: no grants. Goes to IDLE when no valid in shadow pipe and res_valid=0. Goes back to RUN if en returns to 1 first.
- busy = any shadow-pipe valid bit set.
- Simultaneous events:
  - Grant plus stall in the same cycle is impossible, since stall suppresses the grant.
  - en falling in a cycle blocks grants from the next cycle on.
  - A requester dropping req_valid without req_ready is legal; it is not granted.
- Reset mid-operation: in-flight ops are discarded and res_valid drops immediately (async). No result is emitted after reset.

Decomposition:
- Shared package adder_arb_pkg: W, LAT defaults; FSM state enum (IDLE, RUN, DRAIN); tag width function.
- One sub-module: rr_arbiter (N-bit request vector and pointer in; one-hot grant and index out; purely combinational plus pointer register).

Test Plan:
- Reset release: ap_rst_n low then high, en=1, req_valid=0 -> add_rst drops on 2nd edge; idle goes 1 then 0; no res_valid.
- Single op: requester 2 a=0x005, b=0x00A in cycle t -> req_ready=0b0100 at t; res_valid, res_data=0x00F, res_tag=2 at t+2.
- Round robin: all four valid continuously, res_ready=1 -> grant order 0,1,2,3,0…; results back-to-back with tags 0,1,2,3.
- Backpressure: res_ready=0 for 3 cycles while a result is valid -> add_ce=0; no req_ready; res_data/res_tag held; results resume in order with none lost or duplicated.
- Wrap: a=0x7FF, b=0x002 -> res_data=0x001.
- Drain and reset: en=0 with 2 ops in flight -> both results emitted, then idle=1; repeat with ap_rst_n pulsed low mid-flight -> res_valid=0 immediately and no stale results afterwards.
